// File: rtl/tbu_param.sv
// Viterbi traceback unit: stores one frame of survivor decision words, traces
// back from the end state, then streams the decoded bits out in frame order.
module tbu_param #(
    parameter int K  = 4,
    parameter int TB = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  dec_valid,
    input  logic [(1<<(K-1))-1:0] dec_word,
    input  logic                  dec_last,
    input  logic                  tb_mode,
    input  logic [K-2:0]          start_state,
    output logic                  in_ready,
    output logic                  d_o,
    output logic                  d_valid
);

    localparam int NS = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam int AW = (TB > 1) ? $clog2(TB) : 1;

    typedef enum logic [1:0] {WRITE, TRACE, OUT} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wcnt;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   len;
    logic [SW-1:0]   s;
    logic            run_q;
    logic            accept;
    logic            close;
    logic [NS-1:0]   mem [TB];
    logic [TB-1:0]   buffer;

    assign in_ready = (state == WRITE) && run_q;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        close     = 1'b0;
        case (state)
            WRITE: begin
                accept = in_ready && dec_valid && enable;
                close  = accept && (dec_last || (wcnt == AW'(TB - 1)));
                if (close) state_nxt = TRACE;
            end
            TRACE:   if (ptr == '0) state_nxt = OUT;
            OUT:     if (ptr == len) state_nxt = WRITE;
            default: state_nxt = WRITE;
        endcase
        if (!enable) state_nxt = WRITE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WRITE;
        else     state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt    <= '0;
            ptr     <= '0;
            len     <= '0;
            s       <= '0;
            run_q   <= 1'b0;
            d_o     <= 1'b0;
            d_valid <= 1'b0;
        end else begin
            run_q   <= enable;
            d_o     <= 1'b0;
            d_valid <= 1'b0;
            if (!enable) begin
                wcnt <= '0;
                ptr  <= '0;
                len  <= '0;
                s    <= '0;
            end else begin
                case (state)
                    WRITE: begin
                        if (close) begin
                            wcnt <= '0;
                            ptr  <= wcnt;
                            len  <= wcnt;
                            s    <= tb_mode ? start_state : '0;
                        end else if (accept) begin
                            wcnt <= wcnt + AW'(1);
                        end
                    end
                    TRACE: begin
                        s <= {s[SW-2:0], mem[ptr][s]};
                        if (ptr != '0) ptr <= ptr - AW'(1);
                    end
                    OUT: begin
                        d_valid <= 1'b1;
                        d_o     <= buffer[ptr];
                        ptr     <= ptr + AW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: survivor memory and bit buffer carry no reset; each frame overwrites what it reads.
    always_ff @(posedge clk) begin
        if (accept) mem[wcnt] <= dec_word;
        if (enable && (state == TRACE)) buffer[ptr] <= s[SW-1];
    end

endmodule

// File: tb/tb_tbu_param.sv
// Directed bench for tbu_param (K=4, TB=8): table of frames with hand-computed
// decoded bits plus sequences for reset, enable and handshake corner cases.
module tb_tbu_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       dec_valid;
    logic [7:0] dec_word;
    logic       dec_last;
    logic       tb_mode;
    logic [2:0] start_state;
    logic       in_ready;
    logic       d_o;
    logic       d_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tbu_param #(.K(4), .TB(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dec_valid(dec_valid),
        .dec_word(dec_word), .dec_last(dec_last), .tb_mode(tb_mode),
        .start_state(start_state), .in_ready(in_ready), .d_o(d_o), .d_valid(d_valid)
    );

    typedef struct {
        int          n;
        bit          use_last;
        bit          mode;
        logic [2:0]  st;
        logic [63:0] words;
        logic [7:0]  exp_bits;
        bit          hold;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        check({name, "_ready_wait"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send_frame(input vec_t v);
        tb_mode     = v.mode;
        start_state = v.st;
        for (int i = 0; i < v.n; i++) begin
            dec_valid = 1'b1;
            dec_word  = v.words[8*i +: 8];
            dec_last  = v.use_last && (i == v.n - 1);
            step();
        end
        dec_last = 1'b0;
        if (v.hold) dec_word = 8'hFF;
        else        dec_valid = 1'b0;
        // mode inputs change after close to show they were sampled at close
        tb_mode     = ~v.mode;
        start_state = ~v.st;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic [7:0] bits = '0;
        int  vcnt = 0;
        bit  timing_ok = 1'b1;
        bit  ready_ok = 1'b1;
        wait_ready(name);
        send_frame(v);
        for (int c = 1; c <= 2 * v.n + 3; c++) begin
            bit exp_v  = (c >= v.n + 2) && (c <= 2 * v.n + 1);
            bit exp_ir = (c > 2 * v.n);
            if (d_valid !== exp_v) timing_ok = 1'b0;
            if (in_ready !== exp_ir) ready_ok = 1'b0;
            if (d_valid === 1'b1) begin
                if (vcnt < 8) bits[vcnt] = d_o;
                vcnt++;
            end else if (d_o !== 1'b0) begin
                timing_ok = 1'b0;
            end
            if (c == 2 * v.n + 1) dec_valid = 1'b0;
            step();
        end
        check({name, "_dout"}, 32'(bits), 32'(v.exp_bits));
        check({name, "_dvalid_count"}, 32'(vcnt), 32'(v.n));
        check({name, "_dvalid_timing"}, 32'(timing_ok), 32'd1);
        check({name, "_inready_gap"}, 32'(ready_ok), 32'd1);
    endtask

    initial begin
        vecs[0] = '{8, 1'b1, 1'b0, 3'd0, {8{8'h00}}, 8'h00, 1'b0};
        vecs[1] = '{8, 1'b1, 1'b0, 3'd0, {8{8'hFF}}, 8'h1F, 1'b0};
        vecs[2] = '{8, 1'b1, 1'b1, 3'b100, {8{8'h00}}, 8'h80, 1'b0};
        vecs[3] = '{8, 1'b1, 1'b0, 3'd0, {8{8'h01}}, 8'h11, 1'b0};
        vecs[4] = '{4, 1'b1, 1'b1, 3'b010, {8{8'hFF}}, 8'h05, 1'b0};
        vecs[5] = '{1, 1'b1, 1'b1, 3'b111, {8{8'h00}}, 8'h01, 1'b0};
        vecs[6] = '{2, 1'b1, 1'b1, 3'b011, 64'h0800, 8'h01, 1'b0};
        vecs[7] = '{8, 1'b0, 1'b0, 3'd0, {8{8'h00}}, 8'h00, 1'b1};

        rst = 1'b1; enable = 1'b1; dec_valid = 1'b0; dec_word = '0;
        dec_last = 1'b0; tb_mode = 1'b0; start_state = '0;

        // reset state
        step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_d_o", 32'(d_o), 32'd0);
        rst = 1'b0;
        check("release_in_ready_before_edge", 32'(in_ready), 32'd0);
        step();
        check("release_in_ready_after_edge", 32'(in_ready), 32'd1);

        // dec_last without dec_valid must not close a frame
        dec_last = 1'b1;
        step(); step();
        dec_last = 1'b0;
        step();
        check("last_without_valid", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // reset during the third OUT cycle
        begin
            bit quiet = 1'b1;
            wait_ready("rst_out");
            send_frame(vecs[1]);
            for (int c = 1; c < vecs[1].n + 3; c++) step();
            check("rst_out_pre_valid", 32'(d_valid), 32'd1);
            rst = 1'b1;
            #1;
            check("rst_out_drop_valid", 32'(d_valid), 32'd0);
            check("rst_out_in_ready", 32'(in_ready), 32'd0);
            step(); step();
            rst = 1'b0;
            for (int c = 0; c < 20; c++) begin
                step();
                if (d_valid !== 1'b0) quiet = 1'b0;
            end
            check("rst_out_no_more_output", 32'(quiet), 32'd1);
            run_vec("after_rst", vecs[1]);
        end

        // enable low discards a partial frame and clears the word counter
        begin
            bit quiet = 1'b1;
            wait_ready("en");
            tb_mode = 1'b0;
            for (int i = 0; i < 3; i++) begin
                dec_valid = 1'b1; dec_word = 8'h00; dec_last = 1'b0;
                step();
            end
            dec_valid = 1'b0;
            enable = 1'b0;
            step();
            check("en_low_in_ready", 32'(in_ready), 32'd0);
            enable = 1'b1;
            for (int c = 0; c < 4; c++) begin
                step();
                if (d_valid !== 1'b0) quiet = 1'b0;
            end
            check("en_low_no_output", 32'(quiet), 32'd1);
            run_vec("after_en", vecs[4]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tbu_param.md
TBU_PARAM -- requirements
Module: tbu_param

Interface
REQ-001 Parameter K, 4, code constraint length; SHALL support 3..9; NS = 2^(K-1) trellis states.
REQ-002 Parameter TB, 16, maximum frame length in decision words; SHALL support 4..256.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 enable  in  1  synchronous run enable; low SHALL clear the block.
REQ-006 dec_valid  in  1  decision word present.
REQ-007 dec_word  in  NS  survivor decisions; bit s belongs to state s.
REQ-008 dec_last  in  1  qualifies the final word of a frame.
REQ-009 tb_mode  in  1  0 = zero-terminated trellis, 1 = best-state start.
REQ-010 start_state  in  K-1  best end state, used only when tb_mode=1.
REQ-011 in_ready  out  1  block accepts decision words.
REQ-012 d_o  out  1  decoded bit, registered.
REQ-013 d_valid  out  1  d_o qualifier, registered.

Function
REQ-014 A word SHALL be accepted only on a cycle with dec_valid=1 and in_ready=1; it SHALL be written to survivor memory at address wcnt, and wcnt SHALL increment.
REQ-015 FSM states SHALL be WRITE, TRACE and OUT; in_ready SHALL be 1 only in WRITE.
REQ-016 The frame SHALL close on acceptance of a word with dec_last=1, or on acceptance of word TB-1 (forced close); frame length n = words accepted, 1..TB.
REQ-017 On frame close, tb_mode and start_state SHALL be sampled; traceback state s SHALL load start_state if tb_mode=1, else 0; FSM SHALL enter TRACE.
REQ-018 TRACE SHALL take exactly n cycles at addresses a = n-1 down to 0, one per cycle: bit buffer[a] = s[K-2]; s = {s[K-3:0], mem[a][s]}.
REQ-019 After the a=0 step, FSM SHALL enter OUT and present buffer[0..n-1] in ascending order, one bit per cycle, with d_valid=1 for exactly n consecutive cycles.
REQ-020 Timing: close accepted at cycle t; TRACE SHALL span t+1..t+n; d_valid SHALL be high in t+n+2..t+2n+1 (one register stage); in_ready SHALL reassert in the cycle after the last OUT step.
REQ-021 Outside OUT-driven cycles, d_valid and d_o SHALL be 0.
REQ-022 dec_valid during TRACE or OUT SHALL be ignored; no memory write and no wcnt change.
REQ-023 enable=0 SHALL, at the next edge, force WRITE, clear wcnt, s and the frame, and set d_valid=0 and d_o=0; an interrupted frame SHALL be discarded with no partial output.
REQ-024 dec_last with dec_valid=0 SHALL have no effect.

Reset
REQ-025 While rst=1: FSM=WRITE, wcnt=0, s=0, d_o=0, d_valid=0; in_ready SHALL read 0 during reset and 1 from the first edge after release with enable=1.
REQ-026 Reset asserted during TRACE or OUT SHALL immediately drop d_valid and discard the frame; memory contents need not be cleared.

Verification (K=4, TB=8)
REQ-027 8 words of 8'h00, dec_last on the 8th, tb_mode=0 -> d_valid high 8 cycles, d_o = 0,0,0,0,0,0,0,0.
REQ-028 8 words of 8'hFF, tb_mode=0 -> d_o = 1,1,1,1,1,0,0,0 in output order.
REQ-029 8 words of 8'h00, tb_mode=1, start_state=3'b100 -> d_o = 0,0,0,0,0,0,0,1.
REQ-030 8 words with dec_last never asserted -> forced close after word 8, in_ready low 16 cycles, output identical to REQ-027; a 9th dec_valid held high is not accepted until in_ready returns.
REQ-031 Single-word frame (n=1, dec_last on first word, tb_mode=1, start_state=3'b111) -> one d_valid pulse with d_o=1, in_ready back after 2 cycles.
REQ-032 rst pulsed at the 3rd OUT cycle -> d_valid=0 immediately, no further output; new frame after release decodes correctly.
